// File: rtl/pc_ctrl_pkg.sv
// Shared codes for the IF-stage fetch sequencer: PC mux selects and FSM states.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        PC_PLUS_4 = 2'd0,
        PC_JAL    = 2'd1,
        PC_JALR   = 2'd2,
        PC_BRANCH = 2'd3
    } pc_sel_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_e;

endpackage

// File: rtl/pc_redirect_arb.sv
// Redirect priority select: EX branch > EX jalr > ID jal > sequential PC+4.
module pc_redirect_arb
    import pc_ctrl_pkg::*;
(
    input  logic       en,
    input  logic       stall,
    input  logic       jal_taken,
    input  logic       jalr_taken,
    input  logic       branch_taken,
    output logic [1:0] pc_sel,
    output logic       redir,
    output logic       flush_id
);

    logic redir_ex;
    logic redir_id;

    always_comb begin
        redir_ex = branch_taken | jalr_taken;
        // A stalled ID stage re-presents its jal later, so it cannot win now.
        redir_id = jal_taken & ~stall & ~redir_ex;
        pc_sel   = PC_PLUS_4;
        redir    = 1'b0;
        flush_id = 1'b0;
        if (en) begin
            if (branch_taken)    pc_sel = PC_BRANCH;
            else if (jalr_taken) pc_sel = PC_JALR;
            else if (redir_id)   pc_sel = PC_JAL;
            redir    = redir_ex | redir_id;
            flush_id = redir_ex;
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// IF-stage fetch sequencer: one outstanding imem read, fetch buffer, redirect kill.
// Optional perf counters enabled by defining PC_CTRL_PERF_EN.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int XLEN  = 32
`ifdef PC_CTRL_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    input  logic            stall,
    input  logic            jal_taken,
    input  logic            jalr_taken,
    input  logic            branch_taken,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            load,
    output logic [1:0]      pc_sel,
    output logic            imem_req,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            flush_id
`ifdef PC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_fetch,
    output logic [CNT_W-1:0] perf_redirect,
    output logic [CNT_W-1:0] perf_kill
`endif
);

    state_e          state;
    logic            kill;
    logic [XLEN-1:0] issue_pc;
    logic            redir;
    logic            seq_issue;
    logic            ack_drop;

    pc_redirect_arb u_arb (
        .en           (state != IDLE),
        .stall        (stall),
        .jal_taken    (jal_taken),
        .jalr_taken   (jalr_taken),
        .branch_taken (branch_taken),
        .pc_sel       (pc_sel),
        .redir        (redir),
        .flush_id     (flush_id)
    );

    // HOLD with the buffer consumed behaves exactly like ISSUE.
    assign seq_issue = ~redir & ((state == ISSUE) | ((state == HOLD) & ~stall));
    assign imem_req  = seq_issue;
    assign load      = seq_issue | redir;
    assign ack_drop  = (state == WAIT) & imem_ack & (kill | redir);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            kill     <= 1'b0;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
            issue_pc <= '0;
        end else begin
            case (state)
                IDLE: state <= ISSUE;
                ISSUE: begin
                    if (!redir) begin
                        issue_pc <= pc;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        if (kill || redir) begin
                            kill  <= 1'b0;
                            state <= ISSUE;
                        end else begin
                            if_instr <= imem_rdata;
                            if_pc    <= issue_pc;
                            if_valid <= 1'b1;
                            state    <= HOLD;
                        end
                    end else if (redir) begin
                        // Stale read still in flight: absorb its ack before reissuing.
                        kill <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redir) begin
                        if_valid <= 1'b0;
                        state    <= ISSUE;
                    end else if (!stall) begin
                        if_valid <= 1'b0;
                        issue_pc <= pc;
                        state    <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PC_CTRL_PERF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_fetch    <= '0;
            perf_redirect <= '0;
            perf_kill     <= '0;
        end else begin
            if (imem_req) perf_fetch    <= perf_fetch + 1'b1;
            if (redir)    perf_redirect <= perf_redirect + 1'b1;
            if (ack_drop) perf_kill     <= perf_kill + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl with a behavioural PC register and hand-driven imem.
module tb_pc_ctrl;
    localparam int XLEN = 32;
    localparam logic [31:0] T_JAL    = 32'h0000_0100;
    localparam logic [31:0] T_JALR   = 32'h0000_0200;
    localparam logic [31:0] T_BRANCH = 32'h0000_0300;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [XLEN-1:0] pc;
    logic            stall = 1'b0, jal_taken = 1'b0, jalr_taken = 1'b0, branch_taken = 1'b0;
    logic            imem_ack = 1'b0;
    logic [XLEN-1:0] imem_rdata = '0;
    logic            load, imem_req, if_valid, flush_id;
    logic [1:0]      pc_sel;
    logic [XLEN-1:0] if_instr, if_pc;
`ifdef PC_CTRL_PERF_EN
    logic [31:0]     perf_fetch, perf_redirect, perf_kill;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pc_ctrl #(.XLEN(XLEN)) dut (
        .clock(clock), .reset(reset), .pc(pc), .stall(stall),
        .jal_taken(jal_taken), .jalr_taken(jalr_taken), .branch_taken(branch_taken),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .load(load), .pc_sel(pc_sel), .imem_req(imem_req),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .flush_id(flush_id)
`ifdef PC_CTRL_PERF_EN
        , .perf_fetch(perf_fetch), .perf_redirect(perf_redirect), .perf_kill(perf_kill)
`endif
    );

    // External PC register the sequencer steers.
    always @(posedge clock or posedge reset) begin
        if (reset) pc <= '0;
        else if (load) begin
            case (pc_sel)
                2'd0: pc <= pc + 32'd4;
                2'd1: pc <= T_JAL;
                2'd2: pc <= T_JALR;
                default: pc <= T_BRANCH;
            endcase
        end
    end

    function automatic logic [31:0] ins(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    typedef struct {
        logic        stall, jal, jalr, br, ack;
        logic [31:0] rdata;
        logic        e_load;
        logic [1:0]  e_sel;
        logic        e_req, e_flush, e_valid;
        logic [31:0] e_ipc, e_instr;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic j, input logic jr, input logic b,
                         input logic a, input logic [31:0] rd);
        @(negedge clock);
        stall = s; jal_taken = j; jalr_taken = jr; branch_taken = b;
        imem_ack = a; imem_rdata = rd;
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic l, input logic [1:0] sel,
                            input logic rq, input logic fl, input logic v);
        chk({tag, ".load"}, 32'(load), 32'(l));
        chk({tag, ".pc_sel"}, 32'(pc_sel), 32'(sel));
        chk({tag, ".imem_req"}, 32'(imem_req), 32'(rq));
        chk({tag, ".flush_id"}, 32'(flush_id), 32'(fl));
        chk({tag, ".if_valid"}, 32'(if_valid), 32'(v));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // stall jal jalr br ack rdata | load sel req flush valid if_pc if_instr
        vecs[0]  = '{0,0,0,0,0, 32'h0,          0,2'd0,0,0,0, 32'h0,   32'h0};
        vecs[1]  = '{0,0,0,0,0, 32'h0,          1,2'd0,1,0,0, 32'h0,   32'h0};
        vecs[2]  = '{0,0,0,0,1, ins(32'h0),     0,2'd0,0,0,0, 32'h0,   32'h0};
        vecs[3]  = '{0,0,0,0,0, 32'h0,          1,2'd0,1,0,1, 32'h0,   ins(32'h0)};
        vecs[4]  = '{0,0,0,0,1, ins(32'h4),     0,2'd0,0,0,0, 32'h0,   ins(32'h0)};
        vecs[5]  = '{1,0,0,0,0, 32'h0,          0,2'd0,0,0,1, 32'h4,   ins(32'h4)};
        vecs[6]  = '{1,0,0,0,0, 32'h0,          0,2'd0,0,0,1, 32'h4,   ins(32'h4)};
        vecs[7]  = '{1,0,0,0,0, 32'h0,          0,2'd0,0,0,1, 32'h4,   ins(32'h4)};
        vecs[8]  = '{0,0,0,0,0, 32'h0,          1,2'd0,1,0,1, 32'h4,   ins(32'h4)};
        vecs[9]  = '{0,0,0,0,1, ins(32'h8),     0,2'd0,0,0,0, 32'h4,   ins(32'h4)};
        vecs[10] = '{1,1,0,0,0, 32'h0,          0,2'd0,0,0,1, 32'h8,   ins(32'h8)};
        vecs[11] = '{0,1,0,1,0, 32'h0,          1,2'd3,0,1,1, 32'h8,   ins(32'h8)};
        vecs[12] = '{0,0,0,0,0, 32'h0,          1,2'd0,1,0,0, 32'h8,   ins(32'h8)};
        vecs[13] = '{0,0,0,0,1, ins(32'h300),   0,2'd0,0,0,0, 32'h8,   ins(32'h8)};
        vecs[14] = '{0,0,0,0,0, 32'h0,          1,2'd0,1,0,1, 32'h300, ins(32'h300)};
        vecs[15] = '{0,0,1,0,1, ins(32'h304),   1,2'd2,0,1,0, 32'h300, ins(32'h300)};
        vecs[16] = '{0,0,0,0,0, 32'h0,          1,2'd0,1,0,0, 32'h300, ins(32'h300)};
        vecs[17] = '{0,0,0,0,1, ins(32'h200),   0,2'd0,0,0,0, 32'h300, ins(32'h300)};
        vecs[18] = '{1,0,0,0,0, 32'h0,          0,2'd0,0,0,1, 32'h200, ins(32'h200)};

        // Reset state while reset is held.
        repeat (2) @(negedge clock);
        #1;
        chk_outs("reset", 0, 2'd0, 0, 0, 0);
        chk("reset.if_pc", if_pc, 32'h0);
        chk("reset.if_instr", if_instr, 32'h0);

        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 19; i++) begin
            if (i > 0) @(negedge clock);
            stall = vecs[i].stall; jal_taken = vecs[i].jal; jalr_taken = vecs[i].jalr;
            branch_taken = vecs[i].br; imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata;
            #1;
            chk_outs($sformatf("v%0d", i), vecs[i].e_load, vecs[i].e_sel, vecs[i].e_req,
                     vecs[i].e_flush, vecs[i].e_valid);
            chk($sformatf("v%0d.if_pc", i), if_pc, vecs[i].e_ipc);
            chk($sformatf("v%0d.if_instr", i), if_instr, vecs[i].e_instr);
        end
`ifdef PC_CTRL_PERF_EN
        chk("perf_fetch", perf_fetch, 32'd6);
        chk("perf_redirect", perf_redirect, 32'd2);
        chk("perf_kill", perf_kill, 32'd1);
`endif

        // Branch while a 3-cycle read is outstanding: the stale ack must be dropped.
        drive(0,0,0,0,0, 32'h0);
        chk("b0.imem_req", 32'(imem_req), 32'd1);
        drive(0,0,0,1,0, 32'h0);
        chk_outs("b1", 1, 2'd3, 0, 1, 0);
        drive(0,0,0,0,0, 32'h0);
        chk_outs("b2", 0, 2'd0, 0, 0, 0);
        drive(0,0,0,0,1, ins(32'h204));
        chk_outs("b3", 0, 2'd0, 0, 0, 0);
        drive(0,0,0,0,0, 32'h0);
        chk_outs("b4", 1, 2'd0, 1, 0, 0);
        chk("b4.pc", pc, T_BRANCH);
        drive(0,0,0,0,0, 32'h0);
        drive(0,0,0,0,0, 32'h0);
        drive(0,0,0,0,1, ins(32'h300));
        drive(1,0,0,0,0, 32'h0);
        chk("b8.if_valid", 32'(if_valid), 32'd1);
        chk("b8.if_pc", if_pc, 32'h300);
        chk("b8.if_instr", if_instr, ins(32'h300));

        // Reset mid-fetch; a late ack afterwards is ignored and fetch restarts at 0.
        drive(0,0,0,0,0, 32'h0);
        chk("r0.imem_req", 32'(imem_req), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk_outs("r1", 0, 2'd0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk_outs("r2", 0, 2'd0, 0, 0, 0);
        drive(0,0,0,0,1, 32'hDEAD_BEEF);
        chk_outs("r3", 1, 2'd0, 1, 0, 0);
        chk("r3.pc", pc, 32'h0);
        drive(0,0,0,0,0, 32'h0);
        chk("r4.if_valid", 32'(if_valid), 32'd0);
        drive(0,0,0,0,1, ins(32'h0));
        drive(1,0,0,0,0, 32'h0);
        chk("r6.if_valid", 32'(if_valid), 32'd1);
        chk("r6.if_pc", if_pc, 32'h0);
        chk("r6.if_instr", if_instr, ins(32'h0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
